// File: rtl/controle_somador.sv
// controle_somador: round-robin sequencer that shares one external adder
// (somador) and one external load-enabled result register (registrador)
// between two requesters.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req0/a0/b0            requester 0: level request and operands
//   req1/a1/b1            requester 1: level request and operands
//   ack0, ack1            one-cycle completion pulses, one per requester
//   res, res_sinal        registered sum (valid with ack) and its sinal flag
//   busy, grant           not-idle indicator, index of the served requester
//   add_a, add_b          operands to the somador
//   add_soma, add_sinal   somador outputs
//   reg_load, reg_q       registrador load enable and its data output
//
// Sequence: IDLE -> CALC -> LOAD -> RESP -> IDLE, one cycle per non-idle state.
module controle_somador #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH:0]   res,
  output logic             res_sinal,
  output logic             busy,
  output logic             grant,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH:0]   add_soma,
  input  logic             add_sinal,
  output logic             reg_load,
  input  logic [WIDTH:0]   reg_q
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    LOAD = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             grant_q, grant_d;
  logic             prio_q, prio_d;
  logic             res_sinal_q, res_sinal_d;
  logic             sel;

  // The sum travels from the somador straight into the registrador; this
  // block only sequences the load, so the sum itself is not consumed here.
  logic unused_add_soma;
  assign unused_add_soma = ^add_soma;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      grant_q     <= 1'b0;
      prio_q      <= 1'b0;
      res_sinal_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      grant_q     <= grant_d;
      prio_q      <= prio_d;
      res_sinal_q <= res_sinal_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    grant_d     = grant_q;
    prio_d      = prio_q;
    res_sinal_d = res_sinal_q;
    // With a single request, req1 alone names the winner; with both, prio does.
    sel         = (req0 && req1) ? prio_q : req1;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_d = sel;
          op_a_d  = sel ? a1 : a0;
          op_b_d  = sel ? b1 : b0;
          state_d = CALC;
        end
      end
      CALC: state_d = LOAD;
      LOAD: begin
        res_sinal_d = add_sinal;
        state_d     = RESP;
      end
      RESP: begin
        prio_d  = ~grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    reg_load = (state_q == LOAD);
    ack0     = (state_q == RESP) && !grant_q;
    ack1     = (state_q == RESP) &&  grant_q;
    busy     = (state_q != IDLE);
  end

  assign add_a     = op_a_q;
  assign add_b     = op_b_q;
  assign grant     = grant_q;
  assign res_sinal = res_sinal_q;
  assign res       = reg_q;

endmodule

// File: tb/tb_controle_somador.sv
// Bench for controle_somador: behavioural somador/registrador around the DUT,
// directed stimulus pushes hand-computed expectations into a scoreboard, and
// a monitor pops and checks them whenever an ack appears.
module tb_controle_somador;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         ack0, ack1, res_sinal, busy, grant, reg_load, add_sinal;
  logic [W:0]   res, add_soma;
  logic [W-1:0] add_a, add_b;
  logic [W:0]   reg_q = '0;

  always #5 clk = ~clk;

  // somador: 9-bit unsigned sum, sinal taken as the carry bit
  assign add_soma  = {1'b0, add_a} + {1'b0, add_b};
  assign add_sinal = add_soma[W];

  // registrador
  always @(posedge clk) if (reg_load) reg_q <= add_soma;

  controle_somador #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .res(res), .res_sinal(res_sinal),
    .busy(busy), .grant(grant), .add_a(add_a), .add_b(add_b),
    .add_soma(add_soma), .add_sinal(add_sinal),
    .reg_load(reg_load), .reg_q(reg_q)
  );

  typedef struct {
    logic       id;
    logic [W:0] res;
    logic       sinal;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   loads = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic id, input logic [W:0] r, input logic s, input int c);
    exp_t e;
    e.id = id; e.res = r; e.sinal = s; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    check({"idle_", name}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ack0"}, {31'd0, ack0}, 32'd0);
    check({tag, "_ack1"}, {31'd0, ack1}, 32'd0);
    check({tag, "_reg_load"}, {31'd0, reg_load}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_grant"}, {31'd0, grant}, 32'd0);
    check({tag, "_add_a"}, {24'd0, add_a}, 32'd0);
    check({tag, "_add_b"}, {24'd0, add_b}, 32'd0);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      loads = 0;
    end else begin
      if (reg_load) loads++;
      if (ack0 && ack1) begin
        check("two_acks", 32'd1, 32'd0);
      end else if (ack0 || ack1) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", {31'd0, ack1}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("ack_id", {31'd0, ack1}, {31'd0, e.id});
          check("grant", {31'd0, grant}, {31'd0, e.id});
          check("res", {23'd0, res}, {23'd0, e.res});
          check("res_sinal", {31'd0, res_sinal}, {31'd0, e.sinal});
          check("latency", cyc, e.cyc);
          check("loads_per_ack", loads, 32'd1);
        end
        loads = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset
    repeat (3) tick();
    check_quiet("in_reset");
    check("in_reset_res_sinal", {31'd0, res_sinal}, 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    check_quiet("after_reset");

    // Single request 1+1
    req0 = 1'b1; a0 = 8'd1; b0 = 8'd1;
    push(1'b0, 9'd2, 1'b0, cyc + 3);
    tick();
    req0 = 1'b0;
    check("busy_after_grant", {31'd0, busy}, 32'd1);
    wait_idle("single");

    // Carry FF+01
    tick();
    req1 = 1'b1; a1 = 8'hFF; b1 = 8'h01;
    push(1'b1, 9'h100, 1'b1, cyc + 3);
    tick();
    req1 = 1'b0;
    check("grant_carry", {31'd0, grant}, 32'd1);
    wait_idle("carry");

    // Contention, both held: 0, 1, 0 every 4 cycles
    tick();
    req0 = 1'b1; a0 = 8'd3;  b0 = 8'd4;
    req1 = 1'b1; a1 = 8'd10; b1 = 8'd20;
    n = cyc;
    push(1'b0, 9'd7,  1'b0, n + 3);
    push(1'b1, 9'd30, 1'b0, n + 7);
    push(1'b0, 9'd7,  1'b0, n + 11);
    repeat (9) tick();
    req0 = 1'b0; req1 = 1'b0;
    wait_idle("contention");

    // Operand change after grant is ignored
    tick();
    req0 = 1'b1; a0 = 8'd5; b0 = 8'd3;
    push(1'b0, 9'd8, 1'b0, cyc + 3);
    tick();
    a0 = 8'd9; req0 = 1'b0;
    check("add_a_latched", {24'd0, add_a}, 32'd5);
    wait_idle("opchange");

    // Reset during LOAD: dropped, prio returns to 0
    tick();
    req1 = 1'b1; a1 = 8'd1; b1 = 8'd1;
    tick();
    req1 = 1'b0;
    tick();
    check("in_load", {31'd0, reg_load}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_quiet("midop_reset");
    check("midop_res_sinal", {31'd0, res_sinal}, 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("no_resume", {31'd0, busy}, 32'd0);

    // Both request: prio 0 wins, then req1 (2,2) at normal latency
    req0 = 1'b1; a0 = 8'd5; b0 = 8'd6;
    req1 = 1'b1; a1 = 8'd2; b1 = 8'd2;
    n = cyc;
    push(1'b0, 9'd11, 1'b0, n + 3);
    push(1'b1, 9'd4,  1'b0, n + 7);
    tick();
    req0 = 1'b0;
    repeat (4) tick();
    req1 = 1'b0;
    wait_idle("post_reset");

    repeat (3) tick();
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/controle_somador.md
Name: controle_somador

Overview:
- Sequencer and round-robin arbiter that shares one somador (8-bit adder, 9-bit soma, sinal flag) and one registrador (load-enabled result register) between two requesters.
- Captures the winning requester's operands, drives the adder, pulses the register load, then returns the registered sum with a one-cycle ack.
- Sits between client blocks and the shared adder/register pair. The adder and register stay external; this block drives them.

Parameters:
- WIDTH, 8, operand width. Sum and register width is WIDTH+1.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req0  in  1  request from requester 0, level
- a0  in  WIDTH  operand A, requester 0
- b0  in  WIDTH  operand B, requester 0
- req1  in  1  request from requester 1, level
- a1  in  WIDTH  operand A, requester 1
- b1  in  WIDTH  operand B, requester 1
- ack0  out  1  one-cycle completion pulse to requester 0
- ack1  out  1  one-cycle completion pulse to requester 1
- res  out  WIDTH+1  result; equals reg_q; valid only while ack0 or ack1 is high
- res_sinal  out  1  registered copy of the adder sinal for the current result
- busy  out  1  high in any state other than IDLE
- grant  out  1  index of the requester being served; holds its value when idle
- add_a  out  WIDTH  operand A to somador
- add_b  out  WIDTH  operand B to somador
- add_soma  in  WIDTH+1  sum from somador (combinational)
- add_sinal  in  1  sinal from somador
- reg_load  out  1  load enable to registrador
- reg_q  in  WIDTH+1  registrador data_out

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - State goes to IDLE.
  - ack0, ack1, reg_load, busy, grant, res_sinal are all 0.
  - Operand registers are 0, so add_a and add_b are 0.
  - Round-robin pointer prio is 0.
  - An in-flight transaction is dropped with no ack. The transaction is not resumed after rst_n rises.
- States are IDLE -> CALC -> LOAD -> RESP -> IDLE. Each state other than IDLE lasts exactly one cycle.
- IDLE:
  - No req: stay in IDLE.
  - Only one req high: grant that requester.
  - Both req high: grant the requester selected by prio.
  - On the granting edge: latch that requester's a and b into the operand registers, set grant, go to CALC.
- CALC:
  - add_a and add_b come from the operand registers. They stay stable from CALC through RESP.
  - The adder settles during this cycle. Next state is LOAD.
- LOAD:
  - reg_load = 1 for exactly this cycle. The registrador captures add_soma at the edge ending LOAD.
  - add_sinal is captured into res_sinal on the same edge.
  - Next state is RESP.
- RESP:
  - ack[grant] = 1 for exactly this cycle; the other ack stays 0.
  - res = reg_q.
  - prio is set to ~grant at the edge ending RESP. Next state is IDLE.
- Latency: if req is sampled at edge t, ack is high during the cycle after edge t+2 (3 cycles later). Throughput is at most one operation per 4 cycles.
- Handshake rules:
  - A requester holds req and its operands until it is granted. Operands are sampled only at the granting edge; later changes are ignored.
  - If req drops after the grant, the transaction still completes and acks.
  - If req is still high in the IDLE cycle after ack, it is a new request and is arbitrated normally.
  - With both requesters continuously requesting, service strictly alternates.
- Arithmetic: soma = a + b, unsigned, WIDTH+1 bits, carry kept, never truncated. The sinal meaning is defined by somador; this block only passes it through.
- Never asserted: reg_load outside LOAD, two acks at once, or an ack without a preceding LOAD.

Test Plan:
- Reset check: hold rst_n low, then release with no req -> ack0=ack1=reg_load=busy=grant=0, add_a=add_b=0, and state stays IDLE.
- Single request: req0 with a0=8'b00000001, b0=8'b00000001 -> reg_load pulses once, ack0 is high exactly 3 cycles after the sampling edge with res=9'd2 and grant=0, ack1 stays 0.
- Carry: req1 with a1=8'hFF, b1=8'h01 -> ack1 pulse with res=9'h100 (bit 8 set).
- Contention: req0 (3,4) and req1 (10,20) raised together after reset and held -> ack0 with res=7, then ack1 with res=30, then ack0 again. Acks are 4 cycles apart.
- Operand change after grant: a0 changes from 5 to 9 during CALC -> res uses 5 (res = 5 + b0).
- Mid-operation reset: pulse rst_n low during LOAD -> no ack, all outputs 0, prio=0. A following req1 (2,2) completes with res=4 and normal latency.
